fsqrt_sched: RTL and testbench

//  Shares one combinational fsqrt core between NREQ requesters. Round-robin arbitration

---
 rtl/fpu_sched_pkg.sv | 11 +
 rtl/fsqrt.sv | 32 +++
 rtl/fsqrt_sched_arb.sv | 21 ++
 rtl/fsqrt_sched.sv | 72 +++++++
 tb/tb_fsqrt_sched.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_sched_pkg.sv
// fpu_sched_pkg: shared types for the fsqrt scheduler pipeline
package fpu_sched_pkg;
    typedef logic [31:0] fp32_t;
    localparam int MAX_IDW = 3;
    typedef struct packed {
        logic               v;
        logic [MAX_IDW-1:0] id;
        fp32_t              d;
    } sched_stage_t;
    localparam fp32_t FP_ONE = 32'h3F800000;
endpackage

// File: rtl/fsqrt.sv
// fsqrt: combinational single-precision square root, round-to-nearest-even
module fsqrt
    import fpu_sched_pkg::*;
(
    input  fp32_t x,
    output fp32_t y
);
    logic [49:0] rad;
    logic [27:0] rem, trial;
    logic [23:0] root;
    logic [22:0] mant;
    logic [7:0]  e_r;
    // Odd unbiased exponents shift the radicand one extra bit so the root exponent halves exactly.
    always_comb begin
        rad = x[23] ? {2'b01, x[22:0], 25'b0} : {1'b1, x[22:0], 26'b0};
        rem = '0;
        root = '0;
        trial = '0;
        for (int i = 24; i >= 0; i--) begin
            rem = {rem[25:0], rad[2*i+1 -: 2]};
            trial = {2'b00, root, 2'b01};
            root = {root[22:0], rem >= trial};
            rem = root[0] ? rem - trial : rem;
        end
        mant = root[23:1] + 23'(root[0] & (|rem | root[1]));
        e_r = 8'((9'(x[30:23]) + 9'd127) >> 1);
        y = (x[30:23] == 8'd0) ? {x[31], 31'b0} :
            x[31]              ? 32'h7FC00000 :
            (&x[30:23])        ? {x[31:23], x[22] | (|x[22:0]), x[21:0]} :
                                 {1'b0, e_r, mant};
    end
endmodule

// File: rtl/fsqrt_sched_arb.sv
// rr_arbiter: round-robin one-hot grant searching upward from ptr with wrap
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);
    logic [N-1:0] upper, pick;
    always_comb begin
        upper = req & ~((N'(1) << ptr) - N'(1));
        pick = (|upper) ? upper : req;
        gnt = en ? (pick & (~pick + N'(1))) : '0;
        idx = '0;
        for (int k = 0; k < N; k++)
            idx = gnt[k] ? IW'(k) : idx;
    end
endmodule

// File: rtl/fsqrt_sched.sv
// fsqrt_sched: round-robin shared fsqrt core with LAT-stage tagged pipeline and backpressured response
module fsqrt_sched
    import fpu_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int LAT  = 2,
    localparam int IDW = $clog2(NREQ),
    localparam int IFW = $clog2(LAT + 1)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0][31:0] req_x,
    output logic [NREQ-1:0]       req_ready,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [IDW-1:0]        resp_id,
    output logic [31:0]           resp_y,
    output logic [IFW-1:0]        in_flight
);
    sched_stage_t   st_q [LAT];
    sched_stage_t   st_d [LAT];
    sched_stage_t   last;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d, gnt_idx;
    logic           advance, accept, unused_id;
    fp32_t          y;

    assign advance = !resp_valid || resp_ready;
    assign accept = |req_ready;
    assign rr_ptr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;

    // Reset also gates the grant so nothing handshakes while the pipeline is cleared.
    rr_arbiter #(.N(NREQ)) u_arb (
        .req(req_valid),
        .ptr(rr_ptr_q),
        .en (advance && rstn),
        .gnt(req_ready),
        .idx(gnt_idx)
    );

    fsqrt u_fsqrt (.x(st_q[0].d), .y(y));

    always_comb begin
        st_d[0] = sched_stage_t'{v: accept, id: MAX_IDW'(gnt_idx), d: req_x[gnt_idx]};
        for (int i = 1; i < LAT; i++)
            st_d[i] = (i == 1) ? sched_stage_t'{v: st_q[0].v, id: st_q[0].id, d: y} : st_q[i-1];
        last = (LAT == 1) ? sched_stage_t'{v: st_q[0].v, id: st_q[0].id, d: y} : st_q[LAT-1];
        in_flight = '0;
        for (int i = 0; i < LAT; i++)
            in_flight = in_flight + IFW'(st_q[i].v);
    end

    assign resp_valid = last.v;
    assign resp_id = last.id[IDW-1:0];
    assign resp_y = last.d;
    assign unused_id = ^last.id;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr_q <= '0;
            st_q <= '{default: '0};
        end else if (advance) begin
            st_q <= st_d;
            rr_ptr_q <= accept ? rr_ptr_d : rr_ptr_q;
        end
    end

    a_onehot: assert property (@(posedge clk) disable iff (!rstn) $onehot0(req_ready));
    a_stall: assert property (@(posedge clk) disable iff (!rstn)
        resp_valid && !resp_ready |=> $stable(resp_y) && $stable(resp_id));
    a_depth: assert property (@(posedge clk) disable iff (!rstn) int'(in_flight) <= LAT);
endmodule

// File: tb/tb_fsqrt_sched.sv
// tb_fsqrt_sched: directed and random checks of fsqrt_sched against a queue-based model
module tb_fsqrt_sched;
    localparam int NREQ = 4;
    localparam int LAT = 2;

    logic             clk = 1'b0;
    logic             rstn;
    logic [3:0]       req_valid, req_ready;
    logic [3:0][31:0] req_x;
    logic             resp_valid, resp_ready;
    logic [1:0]       resp_id;
    logic [31:0]      resp_y;
    logic [1:0]       in_flight;

    int total = 0;
    int bad = 0;

    typedef struct {
        int          id;
        logic [31:0] y;
        int          age;
    } ent_t;
    ent_t        q[$];
    int          mptr, eid;
    int          wait_n[NREQ];
    logic        exp_v, adv;
    logic [3:0]  eg, acc_m;
    logic [31:0] ytab[4];

    fsqrt_sched #(.NREQ(NREQ), .LAT(LAT)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_x     (req_x),
        .req_ready (req_ready),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_id   (resp_id),
        .resp_y    (resp_y),
        .in_flight (in_flight)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    // Reference sqrt: double-precision $sqrt, then round-to-nearest-even into single.
    function automatic logic [31:0] sqrt_ref(input logic [31:0] x);
        logic [63:0] b;
        logic [23:0] s;
        logic        rnd;
        int          e;
        b = {1'b0, 11'(int'(x[30:23]) - 127 + 1023), x[22:0], 29'b0};
        b = $realtobits($sqrt($bitstoreal(b)));
        e = int'(b[62:52]) - 1023 + 127;
        rnd = b[28] & ((|b[27:0]) | b[29]);
        s = {1'b0, b[51:29]} + 24'(rnd);
        return {1'b0, 8'(e + int'(s[23])), s[22:0]};
    endfunction

    function automatic logic [31:0] rnd_x();
        return {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
    endfunction

    always @(negedge clk) begin
        if (!rstn) begin
            q.delete();
            mptr = 0;
            acc_m = '0;
            for (int i = 0; i < NREQ; i++) wait_n[i] = 0;
        end else begin
            exp_v = (q.size() > 0) ? (q[0].age == LAT) : 1'b0;
            chk("m_resp_valid", resp_valid, exp_v);
            if (exp_v) begin
                chk("m_resp_id", resp_id, q[0].id);
                chk("m_resp_y", resp_y, q[0].y);
            end
            chk("m_in_flight", in_flight, q.size());
            adv = !exp_v || resp_ready;
            eg = '0;
            eid = 0;
            if (adv)
                for (int k = NREQ - 1; k >= 0; k--)
                    if (req_valid[(mptr + k) % NREQ]) begin
                        eid = (mptr + k) % NREQ;
                        eg = 4'b0001 << eid;
                    end
            chk("m_grant", req_ready, eg);
            acc_m = req_valid & req_ready;
            for (int i = 0; i < NREQ; i++) if (!req_valid[i]) wait_n[i] = 0;
            if (adv) begin
                if (exp_v) void'(q.pop_front());
                foreach (q[i]) q[i].age++;
                if (eg != 0) begin
                    for (int i = 0; i < NREQ; i++)
                        if (i != eid && req_valid[i]) begin
                            wait_n[i]++;
                            chk("m_starve", 32'(wait_n[i] < NREQ), 1);
                        end
                    wait_n[eid] = 0;
                    q.push_back(ent_t'{id: eid, y: sqrt_ref(req_x[eid]), age: 1});
                    mptr = (eid + 1) % NREQ;
                end
            end
        end
    end

    initial begin
        rstn = 1'b0;
        req_valid = '0;
        req_x = '0;
        resp_ready = 1'b1;
        ytab = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h3FB504F3};
        chk("ref_sqrt4", sqrt_ref(32'h40800000), 32'h40000000);
        chk("ref_sqrt1", sqrt_ref(32'h3F800000), 32'h3F800000);
        chk("ref_sqrt2", sqrt_ref(32'h40000000), 32'h3FB504F3);
        chk("ref_sqrt9", sqrt_ref(32'h41100000), 32'h40400000);
        @(negedge clk);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_y", resp_y, 0);
        nxt;
        rstn = 1'b1;

        // single op on port 2
        nxt;
        req_valid = 4'b0100;
        req_x[2] = 32'h40800000;
        @(negedge clk);
        chk("t2_grant", req_ready, 4'b0100);
        nxt;
        req_valid = '0;
        @(negedge clk);
        chk("t2_early_valid", resp_valid, 0);
        chk("t2_in_flight", in_flight, 1);
        nxt;
        @(negedge clk);
        chk("t2_resp_valid", resp_valid, 1);
        chk("t2_resp_id", resp_id, 2);
        chk("t2_resp_y", resp_y, 32'h40000000);

        // reset with two ops in flight, pointer left at 3
        nxt;
        req_valid = 4'b0110;
        req_x[1] = 32'h41100000;
        req_x[2] = 32'h41800000;
        @(negedge clk);
        chk("t1_grant1", req_ready, 4'b0010);
        nxt;
        req_valid = 4'b0100;
        @(negedge clk);
        chk("t1_grant2", req_ready, 4'b0100);
        nxt;
        req_valid = 4'b1111;
        @(negedge clk);
        chk("t1_in_flight2", in_flight, 2);
        #2 rstn = 1'b0;
        #1;
        chk("t1_rst_req_ready", req_ready, 0);
        chk("t1_rst_resp_valid", resp_valid, 0);
        chk("t1_rst_resp_id", resp_id, 0);
        chk("t1_rst_resp_y", resp_y, 0);
        chk("t1_rst_in_flight", in_flight, 0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        req_valid = '0;
        @(negedge clk);
        chk("t1_no_resp_a", resp_valid, 0);
        nxt;
        @(negedge clk);
        chk("t1_no_resp_b", resp_valid, 0);

        // round robin with all ports valid
        nxt;
        req_valid = 4'b1111;
        req_x = {32'h40000000, 32'h41800000, 32'h41100000, 32'h40800000};
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("t3_grant", req_ready, 4'b0001 << (k % 4));
            if (k >= 2) begin
                chk("t3_resp_valid", resp_valid, 1);
                chk("t3_resp_id", resp_id, (k - 2) % 4);
                chk("t3_resp_y", resp_y, ytab[(k - 2) % 4]);
            end
            nxt;
        end

        // backpressure with a full pipeline
        resp_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            chk("t4_req_ready", req_ready, 0);
            chk("t4_resp_id", resp_id, 2);
            chk("t4_resp_y", resp_y, 32'h40800000);
            chk("t4_in_flight", in_flight, 2);
            nxt;
        end
        resp_ready = 1'b1;
        @(negedge clk);
        chk("t4_drain_id0", resp_id, 2);
        chk("t4_resume_grant", req_ready, 4'b0001);
        nxt;
        @(negedge clk);
        chk("t4_drain_id1", resp_id, 3);
        nxt;
        @(negedge clk);
        chk("t4_drain_id2", resp_id, 0);
        chk("t4_drain_y2", resp_y, 32'h40000000);
        nxt;
        req_valid = '0;
        repeat (3) nxt;

        // accept on port 3 while a response is consumed
        req_valid = 4'b0001;
        req_x[0] = 32'h40800000;
        @(negedge clk);
        chk("t5_grant0", req_ready, 4'b0001);
        nxt;
        req_valid = '0;
        nxt;
        req_valid = 4'b1000;
        req_x[3] = 32'h3F800000;
        @(negedge clk);
        chk("t5_resp_valid", resp_valid, 1);
        chk("t5_resp_id0", resp_id, 0);
        chk("t5_in_flight_a", in_flight, 1);
        chk("t5_grant3", req_ready, 4'b1000);
        nxt;
        req_valid = '0;
        @(negedge clk);
        chk("t5_in_flight_b", in_flight, 1);
        nxt;
        @(negedge clk);
        chk("t5_resp_id3", resp_id, 3);
        chk("t5_resp_y", resp_y, 32'h3F800000);

        // random traffic, checked by the model each cycle
        for (int c = 0; c < 3000; c++) begin
            nxt;
            for (int i = 0; i < NREQ; i++)
                if (!req_valid[i] || acc_m[i]) begin
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                    req_x[i] = rnd_x();
                end
            resp_ready = ($urandom_range(0, 3) != 0);
        end
        nxt;
        req_valid = '0;
        resp_ready = 1'b1;
        repeat (6) nxt;
        @(negedge clk);
        chk("t6_drained", q.size(), 0);
        chk("t6_idle", resp_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
